draw_cat_sprite: RTL and testbench
==================================

// Module: draw_cat_sprite
// PURPOSE
//  Per-pixel sprite stage upstream of the cat image ROM: forms ROM address/animation state from VGA counters
//  and sprite position, merges 1-cycle-latency ROM pixel onto background with colour-key transparency.
//  Owns cat animation FSM (IDLE/THROW/HIT), switching frames only at frame start. Sits in VGA chain
//  between background stage and next overlay; all timing outputs delayed to match pixel data.
// PARAMETERS
//  SPRITE_W      99      sprite width, px (W*H = 15543 = one ROM image)
//  SPRITE_H      157     sprite height, px
//  KEY_RGB       12'hF0F transparent colour in ROM data
//  THROW_FRAMES  30      video frames THROW image is held
//  HIT_FRAMES    45      video frames HIT image is held
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   async reset, active low
//  hcount_in    in   11  horizontal pixel counter
//  vcount_in    in   11  vertical line counter
//  hsync_in     in   1   hsync
//  vsync_in     in   1   vsync
//  hblnk_in     in   1   horizontal blank
//  vblnk_in     in   1   vertical blank
//  rgb_in       in   12  background pixel
//  xpos         in   11  sprite top-left x
//  ypos         in   11  sprite top-left y
//  throw_req    in   1   1-cycle pulse: start throw animation
//  hit_req      in   1   1-cycle pulse: start hit animation
//  rom_address  out  14  to ROM: rel_y*SPRITE_W + rel_x
//  rom_state    out  2   to ROM: 0 IDLE, 1 THROW, 2 HIT (3 never driven)
//  rom_rgb      in   12  ROM data, valid 1 clk after rom_address/rom_state
//  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  inputs delayed 2 clk
//  rgb_out      out  12  merged pixel, aligned with *_out
//  anim_busy    out  1   1 while FSM not IDLE
// BEHAVIOUR
//  Reset: every output 0, FSM IDLE, pending flags 0, frame counter 0. Async assert, sync-safe deassert.
//  Stage 1 (registered): in_box = hcount_in>=xpos && hcount_in<xpos+SPRITE_W && same for v/ypos/SPRITE_H
//   (compare at 12 bits, no wrap); rom_address = in_box ? rel_y*SPRITE_W+rel_x : 0; timing+rgb_in delayed.
//  Stage 2 (registered): rgb_out = (hblnk|vblnk) ? 0 : (in_box_d && rom_rgb!=KEY_RGB) ? rom_rgb : rgb_in_d.
//  Total latency input->*_out/rgb_out: 2 clk, fixed, no bubbles.
//  Requests latched into pending_throw/pending_hit on any cycle; frame_start = hcount_in==0 && vcount_in==0.
//  FSM evaluated only on frame_start; rom_state updates same cycle as FSM (never mid-frame):
//   IDLE : pending_hit -> HIT; else pending_throw -> THROW; counter loaded with hold-1; pendings cleared.
//   THROW: pending_hit -> HIT (preempt, counter reloaded); else counter==0 -> IDLE; else counter-1.
//   HIT  : counter==0 -> IDLE; else counter-1; pending_throw discarded, pending_hit restarts HIT.
//  throw_req and hit_req same cycle: HIT wins, throw dropped. Request on frame_start cycle counts for next frame.
//  Sprite partly off-screen: only visible pixels drawn; address never exceeds SPRITE_W*SPRITE_H-1.
//  rst_n asserted mid-frame: outputs to 0 immediately, animation aborted to IDLE.
// CONFIGURATION
//  CAT_MIRROR_EN defined: extra port mirror (in, 1); when 1, rel_x replaced by SPRITE_W-1-rel_x
//   (horizontal flip), sampled at frame_start only. Undefined: no port, rel_x used directly.
// TESTING
//  Reset mid-frame with sprite on screen -> all outputs 0 next edge, anim_busy 0, rom_state 0.
//  xpos=100,ypos=50; pixel (100,50) -> rom_address 0; (198,206) -> 15542; (99,50) -> bg passed, address 0.
//  rom_rgb=KEY_RGB inside box -> rgb_out = rgb_in from 2 clk earlier; rom_rgb=12'h123 -> 12'h123; blank -> 0.
//  throw_req mid-frame -> rom_state 1 from next frame_start for exactly 30 frames, then 0; anim_busy matches.
//  throw_req and hit_req same cycle -> rom_state 2 for 45 frames; hit_req during THROW -> HIT next frame.
//  xpos=1000 (sprite clipped right) -> addresses only for hcount<1024 region, none >15542, timing delayed 2 clk.

Source files
------------

// File: rtl/draw_cat_sprite.sv
// rtl/draw_cat_sprite.sv - cat sprite overlay stage: ROM addressing, colour-key merge, IDLE/THROW/HIT animation FSM
// Optional horizontal flip with `define CAT_MIRROR_EN (adds input port mirror).
module draw_cat_sprite #(
   parameter int          SPRITE_W     = 99,
   parameter int          SPRITE_H     = 157,
   parameter logic [11:0] KEY_RGB      = 12'hF0F,
   parameter int          THROW_FRAMES = 30,
   parameter int          HIT_FRAMES   = 45
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [10:0] xpos,
   input  logic [10:0] ypos,
   input  logic        throw_req,
   input  logic        hit_req,
`ifdef CAT_MIRROR_EN
   input  logic        mirror,
`endif
   output logic [13:0] rom_address,
   output logic [1:0]  rom_state,
   input  logic [11:0] rom_rgb,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out,
   output logic        anim_busy
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_THROW = 2'd1, ST_HIT = 2'd2} state_t;

   localparam logic [5:0] THROW_LOAD = 6'(THROW_FRAMES - 1);
   localparam logic [5:0] HIT_LOAD   = 6'(HIT_FRAMES - 1);

   logic        frame_start;
   logic [11:0] hc_ext, vc_ext, x_ext, y_ext;
   logic        in_box;
   logic [10:0] rel_x, rel_y, rel_x_eff;
   logic [13:0] rom_address_d;

   logic        in_box_q;
   logic [13:0] rom_address_q;
   logic [10:0] hcount_s1_q, vcount_s1_q;
   logic        hsync_s1_q, vsync_s1_q, hblnk_s1_q, vblnk_s1_q;
   logic [11:0] rgb_s1_q;

   logic [10:0] hcount_q, vcount_q;
   logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
   logic [11:0] rgb_d, rgb_q;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        pend_throw_q, pend_throw_d;
   logic        pend_hit_q, pend_hit_d;

   assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

   // Box test widened to 12 bits so a sprite near 2047 does not wrap to the left edge.
   assign hc_ext = {1'b0, hcount_in};
   assign vc_ext = {1'b0, vcount_in};
   assign x_ext  = {1'b0, xpos};
   assign y_ext  = {1'b0, ypos};
   assign in_box = (hc_ext >= x_ext) && (hc_ext < x_ext + 12'(SPRITE_W)) &&
                   (vc_ext >= y_ext) && (vc_ext < y_ext + 12'(SPRITE_H));

   assign rel_x = hcount_in - xpos;
   assign rel_y = vcount_in - ypos;

`ifdef CAT_MIRROR_EN
   logic mirror_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           mirror_q <= 1'b0;
      else if (frame_start) mirror_q <= mirror;
   end

   assign rel_x_eff = mirror_q ? (11'(SPRITE_W - 1) - rel_x) : rel_x;
`else
   assign rel_x_eff = rel_x;
`endif

   assign rom_address_d = in_box ? (14'(rel_y) * 14'(SPRITE_W) + 14'(rel_x_eff)) : 14'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_box_q      <= 1'b0;
         rom_address_q <= '0;
         hcount_s1_q   <= '0;
         vcount_s1_q   <= '0;
         hsync_s1_q    <= 1'b0;
         vsync_s1_q    <= 1'b0;
         hblnk_s1_q    <= 1'b0;
         vblnk_s1_q    <= 1'b0;
         rgb_s1_q      <= '0;
      end else begin
         in_box_q      <= in_box;
         rom_address_q <= rom_address_d;
         hcount_s1_q   <= hcount_in;
         vcount_s1_q   <= vcount_in;
         hsync_s1_q    <= hsync_in;
         vsync_s1_q    <= vsync_in;
         hblnk_s1_q    <= hblnk_in;
         vblnk_s1_q    <= vblnk_in;
         rgb_s1_q      <= rgb_in;
      end
   end

   always_comb begin
      rgb_d = rgb_s1_q;
      if (hblnk_s1_q || vblnk_s1_q)              rgb_d = 12'h000;
      else if (in_box_q && (rom_rgb != KEY_RGB)) rgb_d = rom_rgb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q <= '0;
         vcount_q <= '0;
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         hblnk_q  <= 1'b0;
         vblnk_q  <= 1'b0;
         rgb_q    <= '0;
      end else begin
         hcount_q <= hcount_s1_q;
         vcount_q <= vcount_s1_q;
         hsync_q  <= hsync_s1_q;
         vsync_q  <= vsync_s1_q;
         hblnk_q  <= hblnk_s1_q;
         vblnk_q  <= vblnk_s1_q;
         rgb_q    <= rgb_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pend_throw_q <= 1'b0;
         pend_hit_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_throw_q <= pend_throw_d;
         pend_hit_q   <= pend_hit_d;
      end
   end

   // Pendings are consumed at every frame start; a request arriving on that very cycle waits a frame.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_hit_d   = pend_hit_q | hit_req;
      pend_throw_d = pend_throw_q | (throw_req & ~hit_req);
      if (frame_start) begin
         pend_hit_d   = hit_req;
         pend_throw_d = throw_req & ~hit_req;
         case (state_q)
            ST_IDLE: begin
               if (pend_hit_q) begin
                  state_d = ST_HIT;
                  cnt_d   = HIT_LOAD;
               end else if (pend_throw_q) begin
                  state_d = ST_THROW;
                  cnt_d   = THROW_LOAD;
               end
            end
            ST_THROW, ST_HIT: begin
               if (pend_hit_q) begin
                  state_d = ST_HIT;
                  cnt_d   = HIT_LOAD;
               end else if (cnt_q == 6'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 6'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      rom_state = state_q;
      anim_busy = (state_q != ST_IDLE);
   end

   assign rom_address = rom_address_q;
   assign hcount_out  = hcount_q;
   assign vcount_out  = vcount_q;
   assign hsync_out   = hsync_q;
   assign vsync_out   = vsync_q;
   assign hblnk_out   = hblnk_q;
   assign vblnk_out   = vblnk_q;
   assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_draw_cat_sprite.sv
// tb/tb_draw_cat_sprite.sv - self-checking bench for draw_cat_sprite
`timescale 1ns/1ps
module tb_draw_cat_sprite;

   localparam logic [11:0] KEY = 12'hF0F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hcount_in, vcount_in, xpos, ypos;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in, rom_rgb;
   logic        throw_req, hit_req;
   logic [13:0] rom_address;
   logic [1:0]  rom_state;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;
   logic        anim_busy;
`ifdef CAT_MIRROR_EN
   logic        mirror = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   draw_cat_sprite dut (
      .clk(clk), .rst_n(rst_n),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
      .throw_req(throw_req), .hit_req(hit_req),
`ifdef CAT_MIRROR_EN
      .mirror(mirror),
`endif
      .rom_address(rom_address), .rom_state(rom_state), .rom_rgb(rom_rgb),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .anim_busy(anim_busy)
   );

   typedef struct {
      logic [10:0] xp, yp, hc, vc;
      logic        hs, vs, hb, vb;
      logic [11:0] bg, rom;
      logic [13:0] exp_addr;
      logic [11:0] exp_rgb;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_pixel(input logic [10:0] hc, input logic [10:0] vc);
      hcount_in = hc; vcount_in = vc;
      hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
   endtask

   task automatic frame_pulse();
      @(negedge clk);
      hcount_in = 11'd0; vcount_in = 11'd0;
      @(negedge clk);
      hcount_in = 11'd5; vcount_in = 11'd5;
   endtask

   task automatic req_pulse(input logic t, input logic h);
      @(negedge clk);
      throw_req = t; hit_req = h;
      @(negedge clk);
      throw_req = 1'b0; hit_req = 1'b0;
   endtask

   task automatic check_anim(input string name, input logic [1:0] exp_state);
      check(name, {29'd0, anim_busy, rom_state}, {29'd0, exp_state != 2'd0, exp_state});
   endtask

   initial begin
      //         xp    yp    hc    vc   hs vs hb vb  bg      rom     addr   rgb
      vecs[0]  = '{100,  50,  100,  50, 0, 0, 0, 0, 12'hABC, 12'h123, 0,     12'h123};
      vecs[1]  = '{100,  50,  198, 206, 1, 0, 0, 0, 12'h456, KEY,     15542, 12'h456};
      vecs[2]  = '{100,  50,   99,  50, 0, 1, 0, 0, 12'h789, 12'h111, 0,     12'h789};
      vecs[3]  = '{100,  50,  150, 100, 0, 0, 0, 0, 12'h222, 12'h0F0, 5000,  12'h0F0};
      vecs[4]  = '{100,  50,  199,  50, 1, 1, 0, 0, 12'h444, 12'h333, 0,     12'h444};
      vecs[5]  = '{100,  50,  100, 207, 0, 0, 0, 0, 12'h321, 12'h999, 0,     12'h321};
      vecs[6]  = '{100,  50,  120,  60, 0, 0, 1, 0, 12'h666, 12'h555, 1010,  12'h000};
      vecs[7]  = '{100,  50,  101,  51, 0, 0, 0, 1, 12'h777, 12'h888, 100,   12'h000};
      vecs[8]  = '{100,  50,  110,  55, 1, 1, 0, 0, 12'hFFF, KEY,     505,   12'hFFF};
      vecs[9]  = '{1000,  0, 1023,  10, 0, 0, 0, 0, 12'h101, 12'h202, 1013,  12'h202};
      vecs[10] = '{1000,  0, 1000,   0, 0, 0, 0, 0, 12'h303, 12'h0AA, 0,     12'h0AA};
      vecs[11] = '{1000,  0, 1099,  10, 0, 0, 0, 0, 12'h404, 12'h505, 0,     12'h404};
      vecs[12] = '{2000,  0, 2047, 156, 0, 0, 0, 0, 12'h606, 12'h777, 15491, 12'h777};
      vecs[13] = '{2000,  0,    5,   0, 0, 0, 0, 0, 12'h808, 12'h909, 0,     12'h808};
      vecs[14] = '{2000, 2000, 2000, 2046, 0, 0, 0, 0, 12'h2E2, 12'h1E1, 4554, 12'h1E1};

      rst_n = 1'b0;
      drive_pixel(11'd120, 11'd60);
      hsync_in = 1'b1; vsync_in = 1'b1;
      rgb_in = 12'hABC; rom_rgb = 12'h123;
      xpos = 11'd100; ypos = 11'd50;
      throw_req = 1'b0; hit_req = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_addr", {18'd0, rom_address}, 32'd0);
      check("reset_rgb", {20'd0, rgb_out}, 32'd0);
      check("reset_timing", {6'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'd0);
      check_anim("reset_anim", 2'd0);
      rst_n = 1'b1;
      drive_pixel(11'd5, 11'd5);

      // Stream one vector per clock: address checked 1 clk later, merged pixel and timing 2 clk later.
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            check($sformatf("rgb[%0d]", c - 2), {20'd0, rgb_out}, {20'd0, vecs[c-2].exp_rgb});
            check($sformatf("timing[%0d]", c - 2),
                  {6'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
                  {6'd0, vecs[c-2].hc, vecs[c-2].vc, vecs[c-2].hs, vecs[c-2].vs, vecs[c-2].hb, vecs[c-2].vb});
         end
         if (c >= 1 && c <= 15) begin
            check($sformatf("addr[%0d]", c - 1), {18'd0, rom_address}, {18'd0, vecs[c-1].exp_addr});
            rom_rgb = vecs[c-1].rom;
         end
         if (c < 15) begin
            xpos = vecs[c].xp; ypos = vecs[c].yp;
            hcount_in = vecs[c].hc; vcount_in = vecs[c].vc;
            hsync_in = vecs[c].hs; vsync_in = vecs[c].vs;
            hblnk_in = vecs[c].hb; vblnk_in = vecs[c].vb;
            rgb_in = vecs[c].bg;
         end else begin
            xpos = 11'd100; ypos = 11'd50;
            drive_pixel(11'd5, 11'd5);
         end
      end

      // Throw requested mid-frame: THROW for exactly 30 frames.
      req_pulse(1'b1, 1'b0);
      check_anim("throw_before_frame", 2'd0);
      for (int f = 0; f <= 30; f++) begin
         frame_pulse();
         check_anim($sformatf("throw_frame%0d", f), (f < 30) ? 2'd1 : 2'd0);
      end

      // Simultaneous throw and hit: HIT wins, held 45 frames.
      req_pulse(1'b1, 1'b1);
      for (int f = 0; f <= 45; f++) begin
         frame_pulse();
         check_anim($sformatf("both_frame%0d", f), (f < 45) ? 2'd2 : 2'd0);
      end

      // Request on the frame_start cycle is deferred to the next frame.
      @(negedge clk);
      hcount_in = 11'd0; vcount_in = 11'd0; throw_req = 1'b1;
      @(negedge clk);
      hcount_in = 11'd5; vcount_in = 11'd5; throw_req = 1'b0;
      check_anim("fs_req_deferred", 2'd0);
      frame_pulse();
      check_anim("fs_req_taken", 2'd1);
      frame_pulse();
      frame_pulse();
      check_anim("throw_held", 2'd1);

      // Hit during THROW takes effect only at the next frame start.
      req_pulse(1'b0, 1'b1);
      check_anim("hit_pending_midframe", 2'd1);
      frame_pulse();
      check_anim("hit_preempts_throw", 2'd2);

      // Async reset mid-frame with the sprite drawn.
      @(negedge clk);
      drive_pixel(11'd120, 11'd60);
      hsync_in = 1'b1; rgb_in = 12'h456; rom_rgb = 12'h123;
      repeat (3) @(negedge clk);
      check("pre_reset_rgb", {20'd0, rgb_out}, 32'h123);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_addr", {18'd0, rom_address}, 32'd0);
      check("midreset_rgb", {20'd0, rgb_out}, 32'd0);
      check("midreset_timing", {6'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'd0);
      check_anim("midreset_anim", 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_pixel(11'd5, 11'd5);
      frame_pulse();
      check_anim("after_reset_idle", 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
